// File: rtl/axi_pkg.sv
// Shared AXI codes, FSM encodings and the latched burst descriptor for the SRAM slave.
// Purely declarative: no logic, so no latency or backpressure of its own.
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } burst_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; purely combinational, no backpressure.
// WRAP with a length outside {2,4,8,16} beats degrades to INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);
  logic [31:0] step;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic        wrap_ok;

  always_comb begin
    step      = 32'd1 << size;
    incr_addr = addr + step;
    wrap_mask = ((({24'd0, len}) + 32'd1) << size) - 32'd1;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  if (wrap_ok) next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave, one outstanding burst per direction; R beat 0 one cycle after AR, B one cycle after WLAST.
// Stalled R/B hold their outputs stable; ADDR_RANGE_CHECK_EN adds SLVERR for beats outside the BASE window.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          ID_W   = 4,
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 256,
  parameter logic [31:0] BASE   = 32'h0
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [31:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  wr_state_t   w_state, w_state_nxt;
  burst_t      w_burst;
  logic [7:0]  w_cnt;
  logic        w_err_sticky, w_range_err, w_beat_err;
  logic        aw_hs, w_hs, b_hs;
  logic [31:0] w_addr_nxt;

  rd_state_t         r_state, r_state_nxt;
  burst_t            r_burst;
  logic [7:0]        r_cnt;
  logic              ar_hs, r_hs, r_range_err, r_fetch_err;
  logic [31:0]       r_addr_nxt, r_fetch_addr;
  logic [2:0]        r_fetch_size;
  logic [DATA_W-1:0] r_fetch_dat;

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign w_beat_err = (w_burst.size > 3'd2) | w_range_err;

  assign s_axi_arready = (r_state == R_IDLE);
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;
  // On AR accept the first beat is fetched straight from the request; afterwards from the generator.
  assign r_fetch_addr = ar_hs ? s_axi_araddr : r_addr_nxt;
  assign r_fetch_size = ar_hs ? s_axi_arsize : r_burst.size;
  assign r_fetch_err  = (r_fetch_size > 3'd2) | r_range_err;
  assign r_fetch_dat  = r_fetch_err ? '0 : mem[r_fetch_addr[IDX_W+1:2]];

`ifdef ADDR_RANGE_CHECK_EN
  function automatic logic out_of_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return off[32] || (off[31:0] >= 32'(4 * DEPTH));
  endfunction
  assign w_range_err = out_of_range(w_burst.addr);
  assign r_range_err = out_of_range(r_fetch_addr);
`else
  logic unused_cfg;
  assign w_range_err = 1'b0;
  assign r_range_err = 1'b0;
  assign unused_cfg  = ^{BASE, r_fetch_addr[31:IDX_W+2], r_fetch_addr[1:0]};
`endif

  axi_burst_addr_gen u_w_gen (
    .addr(w_burst.addr), .size(w_burst.size), .len(w_burst.len), .burst(w_burst.burst),
    .next_addr(w_addr_nxt)
  );

  axi_burst_addr_gen u_r_gen (
    .addr(r_burst.addr), .size(r_burst.size), .len(r_burst.len), .burst(r_burst.burst),
    .next_addr(r_addr_nxt)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && s_axi_wlast) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_burst      <= '0;
      w_cnt        <= '0;
      w_err_sticky <= 1'b0;
      s_axi_bid    <= '0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (aw_hs) begin
      w_burst      <= '{addr: s_axi_awaddr, len: s_axi_awlen, size: s_axi_awsize, burst: s_axi_awburst};
      w_cnt        <= '0;
      w_err_sticky <= 1'b0;
      s_axi_bid    <= s_axi_awid;
    end else if (w_hs) begin
      w_burst.addr <= w_addr_nxt;
      w_cnt        <= w_cnt + 8'd1;
      w_err_sticky <= w_err_sticky | w_beat_err;
      // wlast terminates the burst even when it disagrees with awlen; the mismatch is reported.
      if (s_axi_wlast)
        s_axi_bresp <= (w_err_sticky || w_beat_err || (w_cnt != w_burst.len)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++)
        if (s_axi_wstrb[b]) mem[w_burst.addr[IDX_W+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && s_axi_rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_burst      <= '0;
      r_cnt        <= '0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rlast  <= 1'b0;
      s_axi_rvalid <= 1'b0;
    end else if (ar_hs) begin
      r_burst      <= '{addr: s_axi_araddr, len: s_axi_arlen, size: s_axi_arsize, burst: s_axi_arburst};
      r_cnt        <= '0;
      s_axi_rid    <= s_axi_arid;
      s_axi_rdata  <= r_fetch_dat;
      s_axi_rresp  <= r_fetch_err ? RESP_SLVERR : RESP_OKAY;
      s_axi_rlast  <= (s_axi_arlen == 8'd0);
      s_axi_rvalid <= 1'b1;
    end else if (r_hs) begin
      if (s_axi_rlast) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end else begin
        r_burst.addr <= r_addr_nxt;
        r_cnt        <= r_cnt + 8'd1;
        s_axi_rdata  <= r_fetch_dat;
        s_axi_rresp  <= r_fetch_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rlast  <= ((r_cnt + 8'd1) == r_burst.len);
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts of each type, stalls, overlap, errors and reset mid-read.
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  int total = 0;
  int bad   = 0;
  logic [31:0] wd   [16];
  logic [3:0]  ws   [16];
  logic [31:0] rexp [16];

  always #5 ACLK = ~ACLK;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                             input logic [1:0] exp_resp, input int bdelay);
    @(negedge ACLK);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    chk("awready", s_axi_awready, 1'b1);
    @(posedge ACLK); #1 s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge ACLK);
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
      chk("wready", s_axi_wready, 1'b1);
      @(posedge ACLK); #1;
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    end
    @(negedge ACLK);
    chk("bvalid", s_axi_bvalid, 1'b1);
    for (int k = 0; k < bdelay; k++) begin
      chk("awready_b_stall", s_axi_awready, 1'b0);
      @(negedge ACLK);
      chk("bvalid_b_stall", s_axi_bvalid, 1'b1);
    end
    chk("bid", s_axi_bid, id);
    chk("bresp", s_axi_bresp, exp_resp);
    s_axi_bready = 1'b1;
    @(posedge ACLK); #1 s_axi_bready = 1'b0;
    chk("awready_after_b", s_axi_awready, 1'b1);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [1:0] exp_resp, input int stall_at);
    @(negedge ACLK);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    chk("arready", s_axi_arready, 1'b1);
    @(posedge ACLK); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge ACLK);
      chk("rvalid", s_axi_rvalid, 1'b1);
      if (i == stall_at) begin
        s_axi_rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge ACLK);
          chk("rdata_stall", s_axi_rdata, rexp[i]);
          chk("rlast_stall", s_axi_rlast, i == int'(len));
          chk("rvalid_stall", s_axi_rvalid, 1'b1);
        end
        s_axi_rready = 1'b1;
      end
      chk("rdata", s_axi_rdata, rexp[i]);
      chk("rlast", s_axi_rlast, i == int'(len));
      chk("rresp", s_axi_rresp, exp_resp);
      chk("rid", s_axi_rid, id);
      @(posedge ACLK); #1;
    end
    s_axi_rready = 1'b0;
    chk("rvalid_end", s_axi_rvalid, 1'b0);
    chk("arready_end", s_axi_arready, 1'b1);
  endtask

  initial begin
    ARESETn = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    for (int i = 0; i < 16; i++) ws[i] = 4'hF;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", s_axi_awready, 1'b1);
    chk("rst_arready", s_axi_arready, 1'b1);
    chk("rst_wready", s_axi_wready, 1'b0);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    chk("rst_rlast", s_axi_rlast, 1'b0);
    chk("rst_bresp", s_axi_bresp, 2'b00);
    chk("rst_rresp", s_axi_rresp, 2'b00);
    chk("rst_bid", s_axi_bid, 4'h0);
    chk("rst_rid", s_axi_rid, 4'h0);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    ARESETn = 1'b1;

    // INCR 4 beats at 0x10 with a delayed bready, read back with a 5-cycle rready stall
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); rexp[i] = 32'(i + 1); end
    write_burst(4'h3, 32'h10, 8'd3, 3'd2, BURST_INCR, 4, RESP_OKAY, 3);
    read_burst(4'h9, 32'h10, 8'd3, 3'd2, BURST_INCR, RESP_OKAY, 1);

    // WRAP write at 0x38 lands at 0x38,0x3C,0x30,0x34
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    write_burst(4'h1, 32'h38, 8'd3, 3'd2, BURST_WRAP, 4, RESP_OKAY, 0);
    rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hA0; rexp[3] = 32'hA1;
    read_burst(4'h2, 32'h30, 8'd3, 3'd2, BURST_INCR, RESP_OKAY, -1);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    read_burst(4'h4, 32'h38, 8'd3, 3'd2, BURST_WRAP, RESP_OKAY, -1);

    // FIXED: last beat wins; then a half-word strobe keeps the upper 16 bits
    wd[0] = 32'hAAAA000A; wd[1] = 32'hBBBB000B; wd[2] = 32'hCCCC000C;
    write_burst(4'h5, 32'h40, 8'd2, 3'd2, BURST_FIXED, 3, RESP_OKAY, 0);
    for (int i = 0; i < 3; i++) rexp[i] = 32'hCCCC000C;
    read_burst(4'h6, 32'h40, 8'd2, 3'd2, BURST_FIXED, RESP_OKAY, -1);
    wd[0] = 32'h11115678; ws[0] = 4'h3;
    write_burst(4'h7, 32'h40, 8'd0, 3'd2, BURST_INCR, 1, RESP_OKAY, 0);
    ws[0] = 4'hF; rexp[0] = 32'hCCCC5678;
    read_burst(4'h8, 32'h40, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, -1);

    // Early and late wlast both end the burst with SLVERR; early beats still land
    wd[0] = 32'h77; wd[1] = 32'h88;
    write_burst(4'hA, 32'hA0, 8'd3, 3'd2, BURST_INCR, 2, RESP_SLVERR, 0);
    rexp[0] = 32'h77; rexp[1] = 32'h88;
    read_burst(4'hB, 32'hA0, 8'd1, 3'd2, BURST_INCR, RESP_OKAY, -1);
    write_burst(4'hC, 32'hB0, 8'd0, 3'd2, BURST_INCR, 2, RESP_SLVERR, 0);

    // Oversized beats: write suppressed, read returns zero with SLVERR
    wd[0] = 32'hFFFFFFFF;
    write_burst(4'hD, 32'h10, 8'd0, 3'd3, BURST_INCR, 1, RESP_SLVERR, 0);
    rexp[0] = 32'h1;
    read_burst(4'hE, 32'h10, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, -1);
    rexp[0] = 32'h0;
    read_burst(4'hE, 32'h10, 8'd0, 3'd3, BURST_INCR, RESP_SLVERR, -1);

    // AW and AR accepted on the same edge; the read sees the pre-write word
    wd[0] = 32'h11111111; wd[1] = 32'h33333333;
    write_burst(4'h1, 32'h80, 8'd1, 3'd2, BURST_INCR, 2, RESP_OKAY, 0);
    @(negedge ACLK);
    s_axi_awid = 4'h5; s_axi_awaddr = 32'h80; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
    s_axi_awburst = BURST_INCR; s_axi_awvalid = 1'b1;
    s_axi_arid = 4'h6; s_axi_araddr = 32'h80; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
    s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    chk("ovl_awready", s_axi_awready, 1'b1);
    chk("ovl_arready", s_axi_arready, 1'b1);
    @(posedge ACLK); #1;
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    chk("ovl_awready_busy", s_axi_awready, 1'b0);
    chk("ovl_arready_busy", s_axi_arready, 1'b0);
    chk("ovl_wready", s_axi_wready, 1'b1);
    chk("ovl_rdata", s_axi_rdata, 32'h11111111);
    chk("ovl_rid", s_axi_rid, 4'h6);
    chk("ovl_rlast", s_axi_rlast, 1'b1);
    @(negedge ACLK);
    s_axi_wdata = 32'h22222222; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_rready = 1'b1;
    @(posedge ACLK); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_rready = 1'b0;
    chk("ovl_rvalid_done", s_axi_rvalid, 1'b0);
    chk("ovl_bvalid", s_axi_bvalid, 1'b1);
    chk("ovl_bid", s_axi_bid, 4'h5);
    s_axi_bready = 1'b1;
    @(posedge ACLK); #1 s_axi_bready = 1'b0;

    // Write beat and read of the same word on one edge: read returns old data
    @(negedge ACLK);
    s_axi_awid = 4'h2; s_axi_awaddr = 32'h84; s_axi_awvalid = 1'b1;
    @(posedge ACLK); #1 s_axi_awvalid = 1'b0;
    @(negedge ACLK);
    s_axi_wdata = 32'h44444444; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_arid = 4'h7; s_axi_araddr = 32'h84; s_axi_arvalid = 1'b1;
    chk("rw_wready", s_axi_wready, 1'b1);
    chk("rw_arready", s_axi_arready, 1'b1);
    @(posedge ACLK); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    chk("rw_old_data", s_axi_rdata, 32'h33333333);
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    @(posedge ACLK); #1;
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    chk("rw_bvalid_done", s_axi_bvalid, 1'b0);
    rexp[0] = 32'h22222222; rexp[1] = 32'h44444444;
    read_burst(4'h3, 32'h80, 8'd1, 3'd2, BURST_INCR, RESP_OKAY, -1);

    // Window check: 0x400 aliases word 0 unless range checking is built in
    wd[0] = 32'h5A5A5A5A;
    write_burst(4'h1, 32'h0, 8'd0, 3'd2, BURST_INCR, 1, RESP_OKAY, 0);
    wd[0] = 32'hDEADBEEF;
`ifdef ADDR_RANGE_CHECK_EN
    write_burst(4'h1, 32'h400, 8'd0, 3'd2, BURST_INCR, 1, RESP_SLVERR, 0);
    rexp[0] = 32'h5A5A5A5A;
`else
    write_burst(4'h1, 32'h400, 8'd0, 3'd2, BURST_INCR, 1, RESP_OKAY, 0);
    rexp[0] = 32'hDEADBEEF;
`endif
    read_burst(4'h2, 32'h0, 8'd0, 3'd2, BURST_INCR, RESP_OKAY, -1);

    // Reset while a read burst is stalled mid-flight
    @(negedge ACLK);
    s_axi_arid = 4'h4; s_axi_araddr = 32'h10; s_axi_arlen = 8'd3; s_axi_arsize = 3'd2;
    s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    @(posedge ACLK); #1 s_axi_arvalid = 1'b0;
    @(negedge ACLK);
    chk("mid_rvalid", s_axi_rvalid, 1'b1);
    chk("mid_rdata", s_axi_rdata, 32'h1);
    #2 ARESETn = 1'b0;
    @(posedge ACLK); #1;
    chk("arst_rvalid", s_axi_rvalid, 1'b0);
    chk("arst_arready", s_axi_arready, 1'b1);
    chk("arst_rlast", s_axi_rlast, 1'b0);
    chk("arst_awready", s_axi_awready, 1'b1);
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 4; i++) rexp[i] = 32'(i + 1);
    read_burst(4'h5, 32'h10, 8'd3, 3'd2, BURST_INCR, RESP_OKAY, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
